lsu_unit: RTL

Load/store unit for the memory stage of the RISC-V core. It turns load/store control from the execute stage into a request/grant/response transaction on the data-memory port. It generates byte enables and lane-replicated store data, and sign- or zero-extends load data. Its registered `loadData_o` drives the memory input of the writeback result mux. It stalls the pipeline until each access completes.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_load_align.sv | 26 ++
 rtl/lsu_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 encodings and byte-enable helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // size is funct3[1:0]; the sign bit does not affect which lanes are touched
    function automatic logic [3:0] lsu_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword from a read word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Memory-stage load/store unit: drives a req/gnt/rvalid data port and stalls the pipeline
// until the access completes; illegal/misaligned accesses are flagged and never issued.
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              memRead_i,
    input  logic              memWrite_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] storeData_i,
    output logic [DATA_W-1:0] loadData_o,
    output logic              stall_o,
    output logic              misaligned_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;

    logic              access, legal_f3, aligned, legal;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] load_ext;

    lsu_load_align u_align (
        .rdata   (dmem_rdata_i),
        .funct3  (f3_q),
        .addr_lo (off_q),
        .data    (load_ext)
    );

    always_comb begin
        access = memRead_i | memWrite_i;
        // a simultaneous read and write is handled as a load
        if (memRead_i) legal_f3 = funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        else           legal_f3 = funct3_i inside {F3_B, F3_H, F3_W};
        case (funct3_i[1:0])
            2'b01:   aligned = ~addr_i[0];
            2'b10:   aligned = (addr_i[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        legal = legal_f3 & aligned;
        case (funct3_i[1:0])
            2'b00:   wdata_rep = {4{storeData_i[7:0]}};
            2'b01:   wdata_rep = {2{storeData_i[15:0]}};
            default: wdata_rep = storeData_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        f3_d    = f3_q;
        off_d   = off_q;
        case (state_q)
            S_IDLE: begin
                if (access && legal) begin
                    state_d = S_REQ;
                    we_d    = ~memRead_i;
                    addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                    be_d    = lsu_be(funct3_i[1:0], addr_i[1:0]);
                    wdata_d = wdata_rep;
                    f3_d    = funct3_i;
                    off_d   = addr_i[1:0];
                end
            end
            S_REQ: begin
                if (dmem_gnt_i) begin
                    if (we_q) begin
                        state_d = S_DONE;
                    end else if (dmem_rvalid_i) begin
                        load_d  = load_ext;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    load_d  = load_ext;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            load_q  <= '0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
        end
    end

    assign stall_o      = (state_q == S_IDLE && access && legal) ||
                          (state_q == S_REQ) || (state_q == S_WAIT);
    assign misaligned_o = (state_q == S_IDLE) && access && !legal;
    assign dmem_req_o   = (state_q == S_REQ);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign loadData_o   = load_q;

endmodule
